// File: rtl/serial_word_receiver.sv
// LSB-first serial word receiver with valid/ready holding register.
// Optional even-parity bit after the data bits: SERIAL_RX_PARITY_EN.
module serial_word_receiver #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             di,
  input  logic             shift_en,
  input  logic             sync,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qv_q, qv_d;
  logic             ov_q, ov_d;
  logic             pe_q, pe_d;
  logic             busy_q;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] done_word;
  logic             done;
  logic             done_pe;

  assign word = {di, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    done      = 1'b0;
    done_word = word;
    done_pe   = 1'b0;
    q_d       = q_q;
    qv_d      = qv_q;
    ov_d      = ov_q;
    pe_d      = pe_q;

    if (shift_en && sync) begin
      sr_d    = word;
      cnt_d   = CW'(1);
      state_d = RECV;
    end else if (shift_en) begin
      unique case (state_q)
        IDLE: begin
          sr_d    = word;
          cnt_d   = CW'(1);
          state_d = RECV;
        end
        RECV: begin
          sr_d = word;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
            done    = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        // sr already holds the full word; the parity bit is not shifted in
        PAR: begin
          state_d   = IDLE;
          done      = 1'b1;
          done_word = sr_q;
          done_pe   = (^sr_q) ^ di;
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end else if (sync) begin
      cnt_d   = '0;
      state_d = IDLE;
    end

    if (done) begin
      if (!qv_q || q_ready) begin
        q_d  = done_word;
        pe_d = done_pe;
        qv_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (qv_q && q_ready) begin
      qv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      ov_q    <= 1'b0;
      pe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      ov_q    <= ov_d;
      pe_q    <= pe_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign q          = q_q;
  assign q_valid    = qv_q;
  assign busy       = busy_q;
  assign overrun    = ov_q;
  assign parity_err = pe_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed self-checking bench for serial_word_receiver (WIDTH=3).
// Parity cases follow SERIAL_RX_PARITY_EN when it is defined.
module tb_serial_word_receiver;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         di = 1'b0;
  logic         shift_en = 1'b0;
  logic         sync = 1'b0;
  logic         q_ready = 1'b0;
  logic [W-1:0] q;
  logic         q_valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int errs = 0;
  int checks = 0;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .di         (di),
    .shift_en   (shift_en),
    .sync       (sync),
    .q          (q),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] seq;  // seq[2] is sent first
    logic [2:0] exp;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string n, input logic [15:0] a,
                     input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b, input logic s);
    di = b;
    shift_en = 1'b1;
    sync = s;
    tick();
    shift_en = 1'b0;
    sync = 1'b0;
    di = 1'b0;
  endtask

  task automatic gap_idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("busy_gap", 16'(busy), 16'd1);
    end
  endtask

  task automatic send(input logic [2:0] d, input int gap, input logic rf);
    for (int i = 0; i < 3; i++) begin
`ifndef SERIAL_RX_PARITY_EN
      if (i == 2) q_ready = rf;
`endif
      bit_in(d[i], 1'b0);
`ifdef SERIAL_RX_PARITY_EN
      gap_idle(gap);
`else
      if (i < 2) gap_idle(gap);
`endif
    end
`ifdef SERIAL_RX_PARITY_EN
    q_ready = rf;
    bit_in(^d, 1'b0);
`endif
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, "_q"}, 16'(q), 16'd0);
    chk({n, "_qv"}, 16'(q_valid), 16'd0);
    chk({n, "_busy"}, 16'(busy), 16'd0);
    chk({n, "_ovr"}, 16'(overrun), 16'd0);
    chk({n, "_pe"}, 16'(parity_err), 16'd0);
  endtask

  initial begin
    logic [2:0] tx;
    int pulses;

    tbl[0] = '{seq: 3'b101, exp: 3'b101};
    tbl[1] = '{seq: 3'b100, exp: 3'b001};
    tbl[2] = '{seq: 3'b111, exp: 3'b111};
    tbl[3] = '{seq: 3'b011, exp: 3'b110};

    // reset with junk inputs
    for (int i = 0; i < 2; i++) begin
      di = 1'($urandom);
      shift_en = 1'($urandom);
      sync = 1'($urandom);
      tick();
    end
    chk_all_zero("rst");
    clr = 1'b0;
    di = 1'b0;
    shift_en = 1'b0;
    sync = 1'b0;
    tick();
    tick();
    chk_all_zero("post_rst");

    // basic frame 1,1,0
    q_ready = 1'b1;
    bit_in(1'b1, 1'b0);
    chk("basic_busy1", 16'(busy), 16'd1);
    chk("basic_qv1", 16'(q_valid), 16'd0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
`ifdef SERIAL_RX_PARITY_EN
    chk("basic_busy_par", 16'(busy), 16'd1);
    bit_in(1'b0, 1'b0);
`endif
    chk("basic_q", 16'(q), 16'h3);
    chk("basic_qv", 16'(q_valid), 16'd1);
    chk("basic_busy", 16'(busy), 16'd0);
    tick();
    chk("basic_qv_drop", 16'(q_valid), 16'd0);

    // gapped 0,0,1
    send(3'b100, 2, 1'b1);
    chk("gap_q", 16'(q), 16'h4);
    chk("gap_qv", 16'(q_valid), 16'd1);

    // loopback from transmitter model loaded with 110
    tx = 3'b110;
    for (int i = 0; i < 3; i++) begin
      bit_in(tx[0], 1'b0);
      tx = tx >> 1;
    end
`ifdef SERIAL_RX_PARITY_EN
    bit_in(1'b0, 1'b0);
`endif
    chk("loop_q", 16'(q), 16'h6);

    // table of back-to-back frames
    for (int v = 0; v < 4; v++) begin
      send({tbl[v].seq[0], tbl[v].seq[1], tbl[v].seq[2]}, 0, 1'b1);
      chk($sformatf("tbl%0d_q", v), 16'(q), 16'(tbl[v].exp));
      chk($sformatf("tbl%0d_qv", v), 16'(q_valid), 16'd1);
    end
    tick();
    chk("tbl_qv_drop", 16'(q_valid), 16'd0);

    // back-pressure
    q_ready = 1'b0;
    send(3'b011, 0, 1'b0);
    chk("bp_q1", 16'(q), 16'h3);
    chk("bp_ovr1", 16'(overrun), 16'd0);
    send(3'b100, 0, 1'b0);
    chk("bp_q2", 16'(q), 16'h3);
    chk("bp_qv2", 16'(q_valid), 16'd1);
    chk("bp_ovr2", 16'(overrun), 16'd1);
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    chk("bp_acc_qv", 16'(q_valid), 16'd0);
    chk("bp_acc_ovr", 16'(overrun), 16'd1);
    chk("bp_acc_q", 16'(q), 16'h3);
    send(3'b101, 0, 1'b0);
    chk("sim_q1", 16'(q), 16'h5);
    send(3'b010, 0, 1'b1);
    chk("sim_q2", 16'(q), 16'h2);
    chk("sim_qv2", 16'(q_valid), 16'd1);
    chk("sim_ovr", 16'(overrun), 16'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovr", 16'(overrun), 16'd0);

    // resync mid-frame
    q_ready = 1'b1;
    pulses = 0;
    bit_in(1'b1, 1'b0);
    pulses += int'(q_valid);
    bit_in(1'b1, 1'b0);
    pulses += int'(q_valid);
    bit_in(1'b0, 1'b1);
    pulses += int'(q_valid);
    bit_in(1'b1, 1'b0);
    pulses += int'(q_valid);
    bit_in(1'b0, 1'b0);
    pulses += int'(q_valid);
`ifdef SERIAL_RX_PARITY_EN
    bit_in(1'b1, 1'b0);
    pulses += int'(q_valid);
`endif
    chk("resync_q", 16'(q), 16'h2);
    tick();
    pulses += int'(q_valid);
    chk("resync_pulses", 16'(pulses), 16'd1);

    bit_in(1'b1, 1'b0);
    chk("sync_busy1", 16'(busy), 16'd1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_busy0", 16'(busy), 16'd0);
    chk("sync_qv", 16'(q_valid), 16'd0);
    send(3'b110, 0, 1'b1);
    chk("sync_after_q", 16'(q), 16'h6);

    // parity / frame length
    tick();
`ifdef SERIAL_RX_PARITY_EN
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    chk("par_ok_q", 16'(q), 16'h6);
    chk("par_ok_pe", 16'(parity_err), 16'd0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    chk("par_bad_q", 16'(q), 16'h6);
    chk("par_bad_pe", 16'(parity_err), 16'd1);
`else
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    chk("nopar_q", 16'(q), 16'h6);
    chk("nopar_qv", 16'(q_valid), 16'd1);
    chk("nopar_pe", 16'(parity_err), 16'd0);
    bit_in(1'b1, 1'b0);
    chk("nopar_4th_busy", 16'(busy), 16'd1);
    chk("nopar_4th_qv", 16'(q_valid), 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
